// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with selectable bit order, downstream stall
// and back-to-back word acceptance. Counts fully consumed words.
//
// state | meaning
// IDLE  | no word held, q idle low, ready for a new word
// SHIFT | word held, q presents the current bit, counter = bits left after q
module piso_serializer #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  din,
  input  logic          dir,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          shift_en,
  output logic          q,
  output logic          q_valid,
  output logic          first,
  output logic          last,
  output logic [CW-1:0] words_sent
);

  localparam int CNTW = $clog2(N);
  localparam logic [CNTW-1:0] CNT_TOP = CNTW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [N-1:0]    sreg, sreg_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic            dir_q, dir_n;
  logic [CW-1:0]   ws_n;
  logic            accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dir_q      <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      cnt        <= cnt_n;
      dir_q      <= dir_n;
      words_sent <= ws_n;
    end
  end

  always_comb begin
    q_valid  = (state == SHIFT);
    q        = q_valid & (dir_q ? sreg[N-1] : sreg[0]);
    first    = q_valid && (cnt == CNT_TOP);
    last     = q_valid && (cnt == '0);
    in_ready = (state == IDLE) || (last && shift_en);
    accept   = in_valid && in_ready;

    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    dir_n   = dir_q;
    ws_n    = words_sent;

    case (state)
      IDLE: ;
      SHIFT: begin
        if (shift_en) begin
          if (cnt != '0) begin
            sreg_n = dir_q ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};
            cnt_n  = cnt - CNTW'(1);
          end else begin
            ws_n    = words_sent + CW'(1);
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A new word overrides the end-of-word return to IDLE (back-to-back).
    if (accept) begin
      sreg_n  = din;
      dir_n   = dir;
      cnt_n   = CNT_TOP;
      state_n = SHIFT;
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter N, default 8, meaning parallel word width in bits; legal range N >= 2.
REQ-002 SHALL have parameter CW, default 16, meaning width of the sent-word counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset, sampled on posedge clk.
REQ-005 SHALL have port din, input, N, the parallel word to serialise.
REQ-006 SHALL have port dir, input, 1, the bit order: 0 = LSB first (right shift), 1 = MSB first (left shift).
REQ-007 SHALL have port in_valid, input, 1, meaning din/dir are offered.
REQ-008 SHALL have port in_ready, output, 1, meaning a word is accepted at this edge if in_valid=1.
REQ-009 SHALL have port shift_en, input, 1, the downstream consume/advance strobe; 0 stalls serial output.
REQ-010 SHALL have port q, output, 1, the serial data bit.
REQ-011 SHALL have port q_valid, output, 1, meaning q carries a word bit.
REQ-012 SHALL have port first, output, 1, meaning q is bit 0 of the current word's transmission order.
REQ-013 SHALL have port last, output, 1, meaning q is the final bit of the current word.
REQ-014 SHALL have port words_sent, output, CW, the count of fully consumed words.

Function
REQ-015 SHALL implement two states: IDLE (no word held) and SHIFT (word held, bits pending).
REQ-016 SHALL drive in_ready = 1 in IDLE, and = (last AND shift_en) in SHIFT; no other case.
REQ-017 SHALL accept a word when in_valid AND in_ready at a clock edge: load shift register with din, latch dir, set bit counter to N-1, enter/stay in SHIFT.
REQ-018 SHALL drive q combinationally from the shift register: bit 0 when latched dir=0, bit N-1 when latched dir=1; q = 0 in IDLE.
REQ-019 SHALL drive q_valid = 1 exactly in SHIFT; first = q_valid AND counter = N-1; last = q_valid AND counter = 0.
REQ-020 SHALL, in SHIFT with shift_en=1 and counter > 0, shift the register toward the output by one (zero fill at the vacated end) and decrement the counter.
REQ-021 SHALL, in SHIFT with shift_en=0, hold shift register, counter, q, q_valid, first, last unchanged.
REQ-022 SHALL, on last AND shift_en: increment words_sent (wraps 2^CW-1 -> 0); then load a new word if in_valid=1 (back-to-back, no gap cycle), else return to IDLE.
REQ-023 SHALL give latency: word accepted at edge k drives its first bit during cycle after edge k; with shift_en held 1, N bits occupy N consecutive cycles; throughput one word per N cycles.
REQ-024 SHALL ignore changes on din and dir while not accepting; dir changes mid-word do not alter current word order.
REQ-025 SHALL ignore in_valid when in_ready=0 (no capture, no error); the source holds din until accepted.

Reset
REQ-026 SHALL, on rst=1 at an edge, clear shift register, counter, latched dir and words_sent to 0 and enter IDLE, taking priority over every other event including a same-cycle accept.
REQ-027 SHALL, after reset, show q=0, q_valid=0, first=0, last=0, in_ready=1, words_sent=0.
REQ-028 SHALL, on reset mid-word, discard the remaining bits without incrementing words_sent.

Verification (N=8, CW=16)
REQ-029 SHALL verify LSB-first: din=8'hA5, dir=0, shift_en=1 -> q = 1,0,1,0,0,1,0,1 over 8 cycles, first on cycle 1, last on cycle 8, words_sent=1.
REQ-030 SHALL verify MSB-first: din=8'hA5, dir=1 -> q = 1,0,1,0,0,1,0,1 order MSB..LSB (8'hA5 palindrome check replaced by 8'h81 -> 1,0,0,0,0,0,0,1 and 8'hC0 -> 1,1,0,0,0,0,0,0).
REQ-031 SHALL verify back-to-back: in_valid held with 8'hFF then 8'h00 -> 16 contiguous q_valid cycles, in_ready high only on the last cycle of word 1, words_sent=2.
REQ-032 SHALL verify stall: shift_en=0 for 3 cycles after bit 2 of 8'h0F (dir=0) -> q held at 1 with q_valid=1, counter frozen, sequence resumes intact, total 11 cycles.
REQ-033 SHALL verify reset mid-word: rst=1 at bit 4 of 8'h3C -> next cycle q_valid=0, in_ready=1, words_sent unchanged; rst coincident with accept -> word not loaded.
REQ-034 SHALL verify wrap: preload 65535 words (or force CW=2, send 4 words) -> words_sent wraps to 0.
